stream_rr_arbiter: RTL



---
 rtl/stream_rr_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: round-robin arbiter feeding one valid/ready byte stream.
// Picks one requesting source per cycle and loads its beat, with the source
// index, into a single-entry output register.
// Optional feature macro: ARB_BURST_LOCK_EN. When it is defined, a grant stays
// on one source for up to MAX_BURST consecutive beats.
module stream_rr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  input  logic                        e_ready_i,
  output logic                        e_valid_o,
  output logic [DATA_W-1:0]           e_data_o,
  output logic [$clog2(NUM_REQ)-1:0]  e_src_o
);

  localparam int SRC_W = $clog2(NUM_REQ);
  localparam int SUM_W = SRC_W + 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1 || MAX_BURST > 15) begin : g_param_check
    $error("stream_rr_arbiter: parameter out of range");
  end

  logic [SRC_W-1:0]  ptr;        // last granted requester
  logic [SRC_W-1:0]  rr_winner;  // first valid source after ptr
  logic [SRC_W-1:0]  winner;     // source granted this cycle
  logic              any_valid;
  logic              pipe_ready;
  logic              accept;
  logic [DATA_W-1:0] win_data;

  // Output register can take a beat when empty or being drained this cycle.
  assign pipe_ready = !e_valid_o || e_ready_i;
  assign accept     = pipe_ready && any_valid && !reset;

  // Round-robin search starting at ptr+1 and wrapping; ptr itself is tried last.
  always_comb begin
    logic [SUM_W-1:0] sum;
    logic [SRC_W-1:0] idx;
    rr_winner = ptr;
    any_valid = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum       = {1'b0, ptr} + SUM_W'(k);
      sum       = (sum >= SUM_W'(NUM_REQ)) ? (sum - SUM_W'(NUM_REQ)) : sum;
      idx       = sum[SRC_W-1:0];
      rr_winner = (!any_valid && req_valid_i[idx]) ? idx : rr_winner;
      any_valid = any_valid | req_valid_i[idx];
    end
  end

`ifdef ARB_BURST_LOCK_EN
  // Beats accepted in the current lock; zero means no lock is held.
  logic [3:0] burst_cnt;
  logic       hold;

  // A lock is held on ptr while that source keeps its request up.
  assign hold = (burst_cnt != 4'd0) && req_valid_i[ptr];

  // Locked source wins over the round-robin choice.
  always_comb begin
    if (hold) begin
      winner = ptr;
    end else begin
      winner = rr_winner;
    end
  end

  // Burst counter: counts lock beats, clears on MAX_BURST or when the source drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      burst_cnt <= 4'd0;
    end else if (accept) begin
      if (hold) begin
        if ((burst_cnt + 4'd1) >= 4'(MAX_BURST)) begin
          burst_cnt <= 4'd0;
        end else begin
          burst_cnt <= burst_cnt + 4'd1;
        end
      end else if (MAX_BURST == 1) begin
        burst_cnt <= 4'd0;
      end else begin
        burst_cnt <= 4'd1;
      end
    end else if (pipe_ready && (burst_cnt != 4'd0) && !req_valid_i[ptr]) begin
      burst_cnt <= 4'd0;
    end else begin
      burst_cnt <= burst_cnt;
    end
  end
`else
  // Without burst lock every accept re-arbitrates.
  always_comb begin
    winner = rr_winner;
  end
`endif

  // Select the winning source's beat.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      win_data = (winner == SRC_W'(i)) ? req_data_i[i*DATA_W +: DATA_W] : win_data;
    end
  end

  // Ready goes only to the granted source, and only when the beat is taken.
  always_comb begin
    req_ready_o         = '0;
    req_ready_o[winner] = accept;
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_valid_o <= 1'b0;
      e_data_o  <= '0;
      e_src_o   <= '0;
      ptr       <= SRC_W'(NUM_REQ - 1);
    end else if (accept) begin
      e_valid_o <= 1'b1;
      e_data_o  <= win_data;
      e_src_o   <= winner;
      ptr       <= winner;
    end else if (e_ready_i) begin
      e_valid_o <= 1'b0;
    end else begin
      e_valid_o <= e_valid_o;
    end
  end

endmodule
